decoder_9b8b_mlane: RTL

Multi-lane, flow-controlled 9b/8b decoder for the calibration receive path. It decodes LANES parallel 9-bit code words into 8-bit data words per beat, using the same bit mapping and Q equations as the single-lane calibration decoder. It adds valid/ready backpressure, per-lane run-length violation detection that spans word boundaries, and a saturating error counter. It sits between the lane deserialisers and the calibration pattern checker.

---
 rtl/decoder_9b8b_mlane.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/decoder_9b8b_mlane.sv
// decoder_9b8b_mlane
//   Multi-lane 9b/8b decoder for the calibration receive path, with
//   valid/ready flow control, per-lane run-length violation detection
//   that spans word boundaries, and a saturating error counter.
//
// Ports
//   clk, rst_n       clock (rising edge), asynchronous active-low reset
//   enable           when low no new beat is accepted; output still drains
//   resync           synchronous pulse clearing per-lane run tracking
//   in_valid/in_ready   input handshake (in_ready is combinational)
//   code_in          LANES x 9-bit code words, lane k at [9k+8:9k]
//   out_valid/out_ready output handshake
//   data_out         LANES x 8-bit decoded words, lane k at [8k+7:8k]
//   code_err         per-lane run-length violation for the beat on data_out
//   err_cnt          saturating count of accepted beats with any lane in error
//   err_cnt_clr      synchronous clear of err_cnt
module decoder_9b8b_mlane #(
  parameter int unsigned LANES     = 2,
  parameter int unsigned MAX_RUN   = 5,
  parameter int unsigned ERR_CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 enable,
  input  logic                 resync,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [9*LANES-1:0]   code_in,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [8*LANES-1:0]   data_out,
  output logic [LANES-1:0]     code_err,
  output logic [ERR_CNT_W-1:0] err_cnt,
  input  logic                 err_cnt_clr
);

  // Run length saturates at MAX_RUN+1: enough to remember "already too long".
  localparam int unsigned      RUN_W   = $clog2(MAX_RUN + 2);
  localparam logic [RUN_W-1:0] RUN_SAT = RUN_W'(MAX_RUN + 1);
  localparam logic [RUN_W-1:0] RUN_LIM = RUN_W'(MAX_RUN);
  localparam logic [RUN_W-1:0] RUN_ONE = RUN_W'(1);

  logic                        accept;

  logic [LANES-1:0]            last_bit_q, last_bit_d;
  logic [LANES-1:0][RUN_W-1:0] run_len_q, run_len_d;
  logic                        out_valid_q, out_valid_d;
  logic [8*LANES-1:0]          data_q, data_d;
  logic [LANES-1:0]            err_q, err_d;
  logic [ERR_CNT_W-1:0]        err_cnt_q, err_cnt_d;

  // Per-lane combinational results for the word currently on code_in.
  logic [8*LANES-1:0]          dec_data;
  logic [LANES-1:0]            lane_err;
  logic [LANES-1:0]            lane_last;
  logic [LANES-1:0][RUN_W-1:0] lane_run;

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    logic [7:0]       dec_l;
    logic             err_l;
    logic             last_l;
    logic [RUN_W-1:0] run_l;

    always_comb begin
      logic [8:0]       w;
      logic             y1, y2, y3, y4;
      logic             prev;
      logic             bitv;
      logic [RUN_W-1:0] run;

      w    = code_in[9*k +: 9];
      y1   = w[6];
      y2   = w[5];
      y3   = w[2];
      y4   = w[1];
      // Code order [B1 X1 Y1 Y2 B2 B3 Y3 Y4 X2] -> data [B1 B2 B3 X1 X2 Q1 Q2 Q3]
      dec_l = {w[8], w[4], w[3], w[7], w[0],
               (y1 ^ y2) & ~(~y3 & y4),
               (y1 ^ y2) & ~(y3 & ~y4),
               (y1 & ~y2) | (~(y1 ^ y2) & y3)};

      // Walk the word MSB first, continuing the run carried in from the
      // previous accepted word. run == 0 means "no history" so the first
      // bit always starts a fresh run.
      err_l = 1'b0;
      run   = resync ? '0 : run_len_q[k];
      prev  = last_bit_q[k];
      bitv  = 1'b0;
      for (int unsigned i = 0; i < 9; i++) begin
        bitv = w[8];
        w    = {w[7:0], 1'b0};
        if ((run != '0) && (bitv == prev)) begin
          if (run != RUN_SAT) begin
            run = run + RUN_ONE;
          end
        end else begin
          run = RUN_ONE;
        end
        prev = bitv;
        if (run > RUN_LIM) begin
          err_l = 1'b1;
        end
      end
      last_l = prev;
      run_l  = run;
    end

    assign dec_data[8*k +: 8] = dec_l;
    assign lane_err[k]        = err_l;
    assign lane_last[k]       = last_l;
    assign lane_run[k]        = run_l;
  end

  assign in_ready = enable & (~out_valid_q | out_ready);
  assign accept   = in_valid & in_ready;

  always_comb begin
    last_bit_d  = last_bit_q;
    run_len_d   = run_len_q;
    out_valid_d = out_valid_q;
    data_d      = data_q;
    err_d       = err_q;

    // Resync with a coinciding accept is already folded into lane_run.
    if (accept) begin
      last_bit_d = lane_last;
      run_len_d  = lane_run;
    end else if (resync) begin
      run_len_d = '0;
    end

    if (accept) begin
      out_valid_d = 1'b1;
      data_d      = dec_data;
      err_d       = lane_err;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end

    // Clear applies first, so clear + erroring accept lands on 1.
    err_cnt_d = err_cnt_clr ? '0 : err_cnt_q;
    if (accept && (|lane_err) && (err_cnt_d != '1)) begin
      err_cnt_d = err_cnt_d + ERR_CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_bit_q  <= '0;
      run_len_q   <= '0;
      out_valid_q <= 1'b0;
      data_q      <= '0;
      err_q       <= '0;
      err_cnt_q   <= '0;
    end else begin
      last_bit_q  <= last_bit_d;
      run_len_q   <= run_len_d;
      out_valid_q <= out_valid_d;
      data_q      <= data_d;
      err_q       <= err_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  assign out_valid = out_valid_q;
  assign data_out  = data_q;
  assign code_err  = err_q;
  assign err_cnt   = err_cnt_q;

endmodule
